// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage sequencer: state encoding and
// default widths used by the sequencer and anything that inspects its state.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_W_DEFAULT = 6;
    localparam int unsigned FETCH_CNT_W  = 8;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer.sv
// Next-PC and fetch-control generator: chooses increment, redirect, stall or
// halt each cycle and times the IF/ID flush window after a redirect.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W           = PC_W_DEFAULT,
    parameter int unsigned RESET_VEC      = 0,
    parameter int unsigned BRANCH_PENALTY = 1
) (
    input  logic                   clck,
    input  logic                   rst,
    input  logic [PC_W-1:0]        pc_cur,
    input  logic                   stall_req,
    input  logic [1:0]             stall_cycles,
    input  logic                   branch_taken,
    input  logic [PC_W-1:0]        branch_target,
    input  logic                   halt,
    output logic [PC_W-1:0]        pc_next,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic [FETCH_CNT_W-1:0] fetch_count,
    output logic [1:0]             state
);

    fetch_state_t state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;

    // NOTE: every output and next-state signal gets a default first so no path
    // through the priority chain leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_next     = pc_cur + PC_W'(1);
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;

        if (rst) begin
            pc_next     = PC_W'(RESET_VEC);
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
        end else if (halt || state_q == HALT) begin
            state_d     = HALT;
            pc_next     = pc_cur;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken) begin
            // A redirect also aborts any stall or flush still counting down.
            pc_next     = branch_target;
            if_id_flush = 1'b1;
            if (BRANCH_PENALTY > 0) begin
                cnt_d   = 2'(BRANCH_PENALTY);
                state_d = FLUSH;
            end else begin
                cnt_d   = 2'd0;
                state_d = RUN;
            end
        end else if (state_q == STALL) begin
            pc_next     = pc_cur;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            cnt_d       = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
                state_d = RUN;
            end
        end else if (stall_req) begin
            pc_next     = pc_cur;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if (stall_cycles != 2'd0) begin
                cnt_d   = stall_cycles;
                state_d = STALL;
            end else begin
                cnt_d   = 2'd0;
                state_d = RUN;
            end
        end else if (state_q == FLUSH) begin
            if_id_flush = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
                state_d = RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clck) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            fetch_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pc_write && fetch_count != '1) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with BRANCH_PENALTY=1.
module tb_fetch_sequencer;

    localparam int unsigned PC_W = 6;

    logic            clck = 1'b0;
    logic            rst;
    logic [PC_W-1:0] pc_cur;
    logic            stall_req;
    logic [1:0]      stall_cycles;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            halt;
    logic [PC_W-1:0] pc_next;
    logic            pc_write;
    logic            if_id_write;
    logic            if_id_flush;
    logic [7:0]      fetch_count;
    logic [1:0]      state;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer #(
        .PC_W          (PC_W),
        .RESET_VEC     (0),
        .BRANCH_PENALTY(1)
    ) dut (
        .clck         (clck),
        .rst          (rst),
        .pc_cur       (pc_cur),
        .stall_req    (stall_req),
        .stall_cycles (stall_cycles),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt),
        .pc_next      (pc_next),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .fetch_count  (fetch_count),
        .state        (state)
    );

    always #5 clck = ~clck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered outputs settle #2 after the edge; inputs then change and
    // combinational outputs are sampled #1 later, well clear of either edge.
    task automatic tick();
        @(posedge clck);
        #2;
    endtask

    initial begin
        rst = 1'b1; pc_cur = '0; stall_req = 1'b0; stall_cycles = 2'd0;
        branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
        tick(); tick();
        #1;
        check("rst_pc_next", pc_next, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_if_id_write", if_id_write, 0);
        check("rst_if_id_flush", if_id_flush, 1);
        check("rst_state", state, 0);
        check("rst_fetch_count", fetch_count, 0);

        // Sequential fetch
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_cur = PC_W'(i);
            #1;
            check("seq_pc_next", pc_next, i + 1);
            check("seq_pc_write", pc_write, 1);
            check("seq_flush", if_id_flush, 0);
            tick();
        end
        check("seq_state", state, 0);
        check("seq_fetch_count", fetch_count, 4);
        pc_cur = 6'd63;
        #1;
        check("wrap_pc_next", pc_next, 0);
        tick();                                   // count 5

        // Multi-cycle stall: 3 cycles without pc_write at pc 5
        pc_cur = 6'd5; stall_req = 1'b1; stall_cycles = 2'd2;
        #1;
        check("stall_req_pc_write", pc_write, 0);
        check("stall_req_if_id_write", if_id_write, 0);
        check("stall_req_pc_next", pc_next, 5);
        tick();
        stall_req = 1'b0; stall_cycles = 2'd0;
        #1;
        check("stall1_state", state, 1);
        check("stall1_pc_write", pc_write, 0);
        check("stall1_pc_next", pc_next, 5);
        tick();
        #1;
        check("stall2_state", state, 1);
        check("stall2_pc_write", pc_write, 0);
        tick();
        #1;
        check("stall_exit_state", state, 0);
        check("stall_exit_pc_write", pc_write, 1);
        check("stall_exit_pc_next", pc_next, 6);
        check("stall_fetch_count", fetch_count, 5);
        tick();                                   // count 6

        // Branch with one-cycle penalty
        pc_cur = 6'd6; branch_taken = 1'b1; branch_target = 6'h20;
        #1;
        check("br_pc_next", pc_next, 6'h20);
        check("br_pc_write", pc_write, 1);
        check("br_flush", if_id_flush, 1);
        tick();                                   // count 7
        branch_taken = 1'b0; pc_cur = 6'h20;
        #1;
        check("br_flush_state", state, 2);
        check("br_flush_flush", if_id_flush, 1);
        check("br_flush_pc_next", pc_next, 6'h21);
        tick();                                   // count 8
        pc_cur = 6'h21;
        #1;
        check("br_done_state", state, 0);
        check("br_done_flush", if_id_flush, 0);
        check("br_done_pc_next", pc_next, 6'h22);
        tick();                                   // count 9

        // Branch and stall together: redirect wins
        pc_cur = 6'h22; branch_taken = 1'b1; branch_target = 6'h10;
        stall_req = 1'b1; stall_cycles = 2'd3;
        #1;
        check("prio_pc_next", pc_next, 6'h10);
        check("prio_pc_write", pc_write, 1);
        tick();                                   // count 10
        branch_taken = 1'b0; stall_req = 1'b0; stall_cycles = 2'd0; pc_cur = 6'h10;
        #1;
        check("prio_state", state, 2);
        tick();                                   // count 11
        check("prio_fetch_count", fetch_count, 11);

        // Branch during STALL with cnt=2 aborts the stall
        pc_cur = 6'h11; stall_req = 1'b1; stall_cycles = 2'd2;
        tick();
        stall_req = 1'b0; stall_cycles = 2'd0;
        branch_taken = 1'b1; branch_target = 6'h30;
        #1;
        check("abort_state_stall", state, 1);
        check("abort_pc_next", pc_next, 6'h30);
        check("abort_pc_write", pc_write, 1);
        check("abort_flush", if_id_flush, 1);
        tick();
        branch_taken = 1'b0; pc_cur = 6'h30;
        #1;
        check("abort_state_flush", state, 2);
        check("abort_flush_pc_next", pc_next, 6'h31);
        tick();
        check("abort_state_run", state, 0);

        // Reset in the second STALL cycle
        pc_cur = 6'h31; stall_req = 1'b1; stall_cycles = 2'd3;
        tick();
        stall_req = 1'b0; stall_cycles = 2'd0;
        tick();
        check("rststall_pre_state", state, 1);
        rst = 1'b1;
        #1;
        check("rststall_pc_next", pc_next, 0);
        check("rststall_flush", if_id_flush, 1);
        tick();
        rst = 1'b0; pc_cur = 6'd0;
        #1;
        check("rststall_state", state, 0);
        check("rststall_pc_write", pc_write, 1);
        check("rststall_fetch_count", fetch_count, 0);
        tick(); pc_cur = 6'd1; tick(); pc_cur = 6'd2; tick();   // count 3

        // Halt is sticky and freezes fetch_count
        pc_cur = 6'd7; halt = 1'b1;
        #1;
        check("halt_pc_write", pc_write, 0);
        check("halt_if_id_write", if_id_write, 0);
        check("halt_flush", if_id_flush, 0);
        check("halt_pc_next", pc_next, 7);
        tick();
        halt = 1'b0; branch_taken = 1'b1; branch_target = 6'h3;
        #1;
        check("halted_state", state, 3);
        check("halted_pc_write", pc_write, 0);
        check("halted_pc_next", pc_next, 7);
        check("halted_flush", if_id_flush, 0);
        branch_taken = 1'b0; stall_req = 1'b1; stall_cycles = 2'd1;
        for (int i = 0; i < 5; i++) tick();
        stall_req = 1'b0; stall_cycles = 2'd0;
        check("halted_state_late", state, 3);
        check("halted_fetch_count", fetch_count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0; pc_cur = 6'd0;
        #1;
        check("unhalt_state", state, 0);
        check("unhalt_pc_write", pc_write, 1);
        check("unhalt_pc_next", pc_next, 1);

        // Saturation after 300 unstalled cycles
        for (int i = 0; i < 300; i++) begin
            pc_cur = PC_W'(i);
            tick();
        end
        check("sat_fetch_count", fetch_count, 255);
        #1;
        check("sat_pc_write", pc_write, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_sequencer
